vme_mem_master: RTL
===================

# vme_mem_master

Bus initiator for the single-cycle VME-style memory interface used by the generated register banks (VMERdMem/VMEWrMem strobes, VMERdDone/VMEWrDone acknowledges). It accepts read/write commands on a valid/ready port and drives one bus transaction per command. It waits for the matching done pulse, bounded by a timeout, and returns read data plus an error flag on a valid/ready response port. It sits between a local controller or test sequencer and any bank that exposes this interface.

## Interface
- ADDR_WIDTH, 8, width of VMEAddr and cmd_addr.
- DATA_WIDTH, 32, width of all data buses.
- TIMEOUT, 255, maximum wait cycles for done after the strobe; legal range 1..65535.
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_wr  out  1  direction of the completed command.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  1 = no done within TIMEOUT.
- VMEAddr  out  ADDR_WIDTH  bus address.
- VMEWrData  out  DATA_WIDTH  bus write data.
- VMERdMem  out  1  read strobe, one-cycle pulse.
- VMEWrMem  out  1  write strobe, one-cycle pulse.
- VMERdData  in  DATA_WIDTH  bus read data; valid when VMERdDone=1.
- VMERdDone  in  1  read acknowledge, one-cycle pulse.
- VMEWrDone  in  1  write acknowledge, one-cycle pulse.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On accept, latch cmd_addr/cmd_wdata/cmd_wr into VMEAddr/VMEWrData/direction register and go to STROBE.
  - STROBE: assert VMERdMem or VMEWrMem for exactly this cycle. Clear the wait counter. Go to WAIT.
  - WAIT: sample only the done of the active direction; the other done is ignored.
    - Done=1: capture VMERdData into rsp_rdata (reads) or 0 (writes), set rsp_err=0, go to RESP.
    - Else increment the counter. When the counter equals TIMEOUT with no done: set rsp_rdata=0, rsp_err=1, go to RESP.
  - RESP: rsp_valid=1; rsp_wr/rsp_rdata/rsp_err held stable. On rsp_ready, go to IDLE.
- cmd_ready=0 in every state except IDLE. One transaction is outstanding at most.
- VMEAddr/VMEWrData hold their values from STROBE until the next accept. VMEWrData is loaded on reads as well.
- Done asserted during STROBE, IDLE or RESP is ignored. A late done after a timeout is ignored.
- Counter width is ceil(log2(TIMEOUT+1)) bits and never wraps.
- Reset: after a rising Clk edge with Rst=1, the block takes these values:
  - state IDLE, cmd_ready=1;
  - VMERdMem=0, VMEWrMem=0;
  - VMEAddr=0, VMEWrData=0;
  - rsp_valid=0, rsp_wr=0, rsp_rdata=0, rsp_err=0.
- Reset mid-transaction aborts it: the strobe drops, any pending response is discarded, and no response is ever emitted for the aborted command.

## Timing
- Accept in cycle T → strobe high in T+1 only.
- Done arriving in cycle T+1+k (1 ≤ k ≤ TIMEOUT) → rsp_valid high from T+2+k.
- Done at exactly k=TIMEOUT is a success.
- With no done, rsp_valid with rsp_err=1 is high from T+2+TIMEOUT.
- Reference slave (RdDone 1 cycle after RdMem, WrDone 2 cycles after WrMem):
  - read: accept T → rsp_valid T+3;
  - write: accept T → rsp_valid T+4.
- Response handshake in cycle R → cmd_ready=1 in R+1. Back-to-back read throughput is one command per 4 cycles.
- rsp_valid never drops without a handshake.

## Test plan
- Read, slave returns 0x000000A5 one cycle after VMERdMem → VMERdMem high exactly 1 cycle; rsp_valid 3 cycles after accept; rsp_rdata=0x000000A5, rsp_err=0, rsp_wr=0.
- Write 0x12345678 to address 0x04, WrDone 2 cycles after strobe → VMEAddr=0x04 and VMEWrData=0x12345678 at the strobe; rsp_valid 4 cycles after accept; rsp_err=0, rsp_rdata=0.
- TIMEOUT=4, no done → rsp_err=1 and rsp_rdata=0 at accept+6. A done at accept+7 is ignored; cmd_ready returns after rsp_ready.
- TIMEOUT=4, done exactly 4 cycles after strobe → rsp_err=0. Wrong-direction done (VMEWrDone during a read) → ignored and the read still times out.
- rsp_ready held low 10 cycles → rsp_valid and payload stable; cmd_ready=0; a cmd_valid pulse is not accepted.
- Rst pulsed one cycle during WAIT → strobes 0 and state IDLE next cycle. A subsequent done produces no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/vme_mem_master_if.sv
// vme_mem_master_if: command/response handshakes and VME memory bus of vme_mem_master
interface vme_mem_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_wr;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] VMEAddr;
    logic [DATA_WIDTH-1:0] VMEWrData;
    logic                  VMERdMem;
    logic                  VMEWrMem;
    logic [DATA_WIDTH-1:0] VMERdData;
    logic                  VMERdDone;
    logic                  VMEWrDone;
    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, VMERdData, VMERdDone, VMEWrDone,
        output cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, VMERdData, VMERdDone, VMEWrDone,
        input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err, VMEAddr, VMEWrData, VMERdMem, VMEWrMem
    );
endinterface

// File: rtl/vme_mem_master.sv
// vme_mem_master: one-outstanding VME memory initiator with done timeout and valid/ready response
module vme_mem_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic               Clk,
    input  logic               Rst,
    vme_mem_master_if.master   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, RESP} state_t;
    state_t                state, state_n;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [CW-1:0]         cnt, cnt_inc;
    logic                  done, hit_to;
    assign done    = wr_q ? bus.VMEWrDone : bus.VMERdDone;
    assign cnt_inc = cnt + 1'b1;
    assign hit_to  = cnt_inc == TO;
    assign bus.VMEAddr   = addr_q;
    assign bus.VMEWrData = wdata_q;
    assign bus.rsp_wr    = wr_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    always_comb begin
        state_n       = state;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.VMERdMem  = 1'b0;
        bus.VMEWrMem  = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                state_n = bus.cmd_valid ? STROBE : IDLE;
            end
            STROBE: begin
                bus.VMERdMem = !wr_q;
                bus.VMEWrMem = wr_q;
                state_n = WAIT;
            end
            WAIT: state_n = (done || hit_to) ? RESP : WAIT;
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_n = bus.rsp_ready ? IDLE : RESP;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && bus.cmd_valid) begin
                wr_q    <= bus.cmd_wr;
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
            end
            if (state == STROBE) cnt <= '0;
            else if (state == WAIT && !done && !hit_to) cnt <= cnt_inc;
            // a done in the timeout cycle still wins over the error
            if (state == WAIT && (done || hit_to)) begin
                rdata_q <= (done && !wr_q) ? bus.VMERdData : '0;
                err_q   <= !done;
            end
        end
    end
endmodule
